// File: rtl/omsp_dadd_seq.sv
// Sequential BCD adder: adds two 16-bit BCD operands one nibble per clock cycle.
// Word mode processes four nibbles and byte mode processes two; the result and flags are held until the next operation.
module omsp_dadd_seq (
   input  logic        mclk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        clear,
   input  logic        byte_mode,
   input  logic [15:0] op_src,
   input  logic [15:0] op_dst,
   input  logic        carry_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        flag_c,
   output logic        flag_z,
   output logic        flag_n,
   output logic        flag_v
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      state_q;
   logic [1:0]  nib_cnt_q;
   logic [15:0] src_q, dst_q;
   logic        byte_q;
   logic        carry_q;
   logic [15:0] acc_q;
   logic [15:0] result_q;
   logic        busy_q, done_q;
   logic        flag_c_q, flag_z_q, flag_n_q;

   logic [3:0]  src_nib, dst_nib, digit;
   logic [4:0]  sum;
   logic        nib_c;
   logic [15:0] acc_d;
   logic        last_nib, zero_d, neg_d;

   // Partial digits are collected in acc_q, so an aborted operation never touches result_q.
   always_comb begin
      src_nib  = src_q[{nib_cnt_q, 2'b00} +: 4];
      dst_nib  = dst_q[{nib_cnt_q, 2'b00} +: 4];
      sum      = {1'b0, src_nib} + {1'b0, dst_nib} + {4'b0000, carry_q};
      if (sum >= 5'd10) begin
         digit = sum[3:0] + 4'd6;
         nib_c = 1'b1;
      end else begin
         digit = sum[3:0];
         nib_c = 1'b0;
      end
      acc_d                            = acc_q;
      acc_d[{nib_cnt_q, 2'b00} +: 4]   = digit;
      last_nib = byte_q ? (nib_cnt_q == 2'd1) : (nib_cnt_q == 2'd3);
      zero_d   = byte_q ? (acc_d[7:0] == 8'h00) : (acc_d == 16'h0000);
      neg_d    = byte_q ? acc_d[7] : acc_d[15];
   end

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         nib_cnt_q <= 2'd0;
         src_q     <= 16'h0000;
         dst_q     <= 16'h0000;
         byte_q    <= 1'b0;
         carry_q   <= 1'b0;
         acc_q     <= 16'h0000;
         result_q  <= 16'h0000;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         flag_c_q  <= 1'b0;
         flag_z_q  <= 1'b0;
         flag_n_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (clear) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            nib_cnt_q <= 2'd0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (start) begin
                     src_q     <= op_src;
                     dst_q     <= op_dst;
                     byte_q    <= byte_mode;
                     carry_q   <= carry_in;
                     acc_q     <= 16'h0000;
                     nib_cnt_q <= 2'd0;
                     busy_q    <= 1'b1;
                     state_q   <= StRun;
                  end
               end
               StRun: begin
                  acc_q     <= acc_d;
                  carry_q   <= nib_c;
                  nib_cnt_q <= nib_cnt_q + 2'd1;
                  if (last_nib) begin
                     state_q  <= StDone;
                     done_q   <= 1'b1;
                     result_q <= acc_d;
                     flag_c_q <= nib_c;
                     flag_z_q <= zero_d;
                     flag_n_q <= neg_d;
                  end
               end
               StDone: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign flag_c = flag_c_q;
   assign flag_z = flag_z_q;
   assign flag_n = flag_n_q;
   assign flag_v = 1'b0;

endmodule

// File: tb/tb_omsp_dadd_seq.sv
// Scoreboard bench for omsp_dadd_seq: the stimulus pushes hand-computed results into a queue.
// A monitor pops an entry and checks result, flags and latency on every done pulse.
module tb_omsp_dadd_seq;

   logic        mclk = 1'b0;
   logic        reset_n;
   logic        start, clear, byte_mode, carry_in;
   logic [15:0] op_src, op_dst;
   logic        busy, done, flag_c, flag_z, flag_n, flag_v;
   logic [15:0] result;

   typedef struct {
      logic [15:0] res;
      logic        c;
      logic        z;
      logic        n;
      int          start_cyc;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errs   = 0;
   int   cyc      = 0;
   logic prev_done = 1'b0;

   omsp_dadd_seq dut (
      .mclk      (mclk),
      .reset_n   (reset_n),
      .start     (start),
      .clear     (clear),
      .byte_mode (byte_mode),
      .op_src    (op_src),
      .op_dst    (op_dst),
      .carry_in  (carry_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .flag_v    (flag_v)
   );

   always #5 mclk = ~mclk;

   always @(posedge mclk) cyc = cyc + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge mclk) begin
      if (done) begin
         if (prev_done) begin
            n_checks++;
            n_errs++;
            $display("FAIL done_width: done high for more than one cycle (cycle %0d)", cyc);
         end
         if (q.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL spurious_done: got done=1, expected no completion (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result", result, e.res);
            check("flag_c", 16'(flag_c), 16'(e.c));
            check("flag_z", 16'(flag_z), 16'(e.z));
            check("flag_n", 16'(flag_n), 16'(e.n));
            check("flag_v", 16'(flag_v), 16'h0000);
            check("latency", 16'(cyc - e.start_cyc), 16'(e.lat));
         end
      end
      prev_done = done;
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy || q.size() != 0) && n < 20) begin
         @(negedge mclk);
         n++;
      end
      if (n >= 20) begin
         n_checks++;
         n_errs++;
         $display("FAIL timeout: got busy=%0b pending=%0d, expected idle with no pending", busy,
                  q.size());
         q.delete();
      end
   endtask

   task automatic issue(input logic bm, input logic [15:0] s, input logic [15:0] d,
                        input logic ci);
      @(negedge mclk);
      byte_mode = bm;
      op_src    = s;
      op_dst    = d;
      carry_in  = ci;
      start     = 1'b1;
   endtask

   task automatic run_op(input logic bm, input logic [15:0] s, input logic [15:0] d,
                         input logic ci, input logic [15:0] er, input logic ec,
                         input logic ez, input logic en);
      exp_t e;
      issue(bm, s, d, ci);
      e.res = er; e.c = ec; e.z = ez; e.n = en;
      e.start_cyc = cyc + 1;
      e.lat = bm ? 2 : 4;
      q.push_back(e);
      @(negedge mclk);
      start = 1'b0;
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      reset_n = 1'b0; start = 1'b0; clear = 1'b0; byte_mode = 1'b0; carry_in = 1'b0;
      op_src = 16'h0000; op_dst = 16'h0000;
      #1;
      check("rst_busy", 16'(busy), 16'h0000);
      check("rst_done", 16'(done), 16'h0000);
      check("rst_result", result, 16'h0000);
      check("rst_flags", 16'({flag_c, flag_z, flag_n, flag_v}), 16'h0000);
      repeat (2) @(negedge mclk);
      reset_n = 1'b1;
      @(negedge mclk);

      run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
      run_op(1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      run_op(1'b1, 16'h0099, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
      run_op(1'b1, 16'h1299, 16'h3401, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
      run_op(1'b1, 16'h5655, 16'h7745, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      run_op(1'b1, 16'h0045, 16'h0040, 1'b0, 16'h0085, 1'b0, 1'b0, 1'b1);
      run_op(1'b0, 16'h000F, 16'h000F, 1'b0, 16'h0014, 1'b0, 1'b0, 1'b0);
      run_op(1'b0, 16'h8000, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);

      // A second start during RUN must neither re-latch the operands nor restart the operation.
      issue(1'b0, 16'h1234, 16'h4321, 1'b0);
      e.res = 16'h5555; e.c = 1'b0; e.z = 1'b0; e.n = 1'b0;
      e.start_cyc = cyc + 1; e.lat = 4;
      q.push_back(e);
      @(negedge mclk);
      start = 1'b0;
      @(negedge mclk);
      op_src = 16'h9999; op_dst = 16'h0001; carry_in = 1'b1; start = 1'b1;
      @(negedge mclk);
      start = 1'b0;
      wait_idle();

      // Clear at the second RUN cycle: no done, and the previous result and flags are kept.
      issue(1'b0, 16'h9999, 16'h0001, 1'b0);
      @(negedge mclk);
      start = 1'b0;
      @(negedge mclk);
      clear = 1'b1;
      @(negedge mclk);
      clear = 1'b0;
      check("clr_busy", 16'(busy), 16'h0000);
      check("clr_result", result, 16'h5555);
      check("clr_flags", 16'({flag_c, flag_z, flag_n}), 16'h0000);
      repeat (6) @(negedge mclk);
      check("clr_still_idle", 16'(busy), 16'h0000);

      // Start together with clear in IDLE stays in IDLE.
      issue(1'b0, 16'h1111, 16'h1111, 1'b0);
      clear = 1'b1;
      @(negedge mclk);
      start = 1'b0; clear = 1'b0;
      check("startclr_busy", 16'(busy), 16'h0000);
      repeat (6) @(negedge mclk);
      check("startclr_result", result, 16'h5555);

      run_op(1'b0, 16'h9999, 16'h0099, 1'b0, 16'h0098, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of RUN, between clock edges.
      issue(1'b0, 16'h9999, 16'h0001, 1'b0);
      @(negedge mclk);
      start = 1'b0;
      @(negedge mclk);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_busy", 16'(busy), 16'h0000);
      check("arst_done", 16'(done), 16'h0000);
      check("arst_result", result, 16'h0000);
      check("arst_flags", 16'({flag_c, flag_z, flag_n, flag_v}), 16'h0000);
      repeat (2) @(negedge mclk);
      reset_n = 1'b1;
      repeat (4) @(negedge mclk);
      check("post_rst_idle", 16'(busy), 16'h0000);
      run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge mclk);
      if (q.size() != 0) begin
         n_checks++;
         n_errs++;
         $display("FAIL missing_done: got %0d pending, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
      $finish;
   end

endmodule
